// File: rtl/ryu_pkg.sv
// Shared types and constants for the Ryu punch sprite fetch path.
package ryu_pkg;

  // Punch animation phases, in sequence order
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WINDUP  = 2'd1,
    EXTEND  = 2'd2,
    RECOVER = 2'd3
  } anim_state_e;

  // Default sprite geometry and ROM layout
  localparam int SPR_W_DEF       = 64;
  localparam int SPR_H_DEF       = 96;
  localparam int FRAMES_DEF      = 3;
  localparam int FRAME_TICKS_DEF = 4;
  localparam int ADDR_W_DEF      = 15;

  // ROM frame numbers
  localparam logic [1:0] FRM_IDLE = 2'd0;
  localparam logic [1:0] FRM_WIND = 2'd1;
  localparam logic [1:0] FRM_EXT  = 2'd2;

endpackage

// File: rtl/ryu_punch_anim_fsm.sv
// Punch animation sequencer: counts frame_tick pulses per phase and
// selects which ROM frame the fetch pipeline reads. All outputs registered.
module ryu_punch_anim_fsm
  import ryu_pkg::*;
#(
  parameter int FRAME_TICKS = FRAME_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       punch_req,
  output logic [1:0] frame,
  output logic       busy,
  output logic       done
);

  // Counter must reach 2*FRAME_TICKS-1 during EXTEND
  localparam int CNT_W = (2 * FRAME_TICKS > 2) ? $clog2(2 * FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST_SHORT = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] LAST_LONG  = CNT_W'(2 * FRAME_TICKS - 1);

  anim_state_e      state;
  logic [CNT_W-1:0] cnt;

  // Phase sequencing; phase changes after IDLE happen only on frame_tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      frame <= FRM_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A tick coinciding with the request is deliberately not counted
          if (punch_req) begin
            state <= WINDUP;
            cnt   <= '0;
            frame <= FRM_WIND;
            busy  <= 1'b1;
          end
        end
        WINDUP: begin
          if (frame_tick) begin
            if (cnt == LAST_SHORT) begin
              state <= EXTEND;
              cnt   <= '0;
              frame <= FRM_EXT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        EXTEND: begin
          if (frame_tick) begin
            if (cnt == LAST_LONG) begin
              state <= RECOVER;
              cnt   <= '0;
              frame <= FRM_WIND;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          if (frame_tick) begin
            if (cnt == LAST_SHORT) begin
              state <= IDLE;
              cnt   <= '0;
              frame <= FRM_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ryu_punch_sprite_fetch.sv
// Per-pixel sprite hit test and ROM fetch for the Ryu punch sprite.
// Three-stage fixed-latency pipeline: address -> ROM data -> palette index.
module ryu_punch_sprite_fetch
  import ryu_pkg::*;
#(
  parameter int SPR_W       = SPR_W_DEF,
  parameter int SPR_H       = SPR_H_DEF,
  parameter int FRAMES      = FRAMES_DEF,
  parameter int FRAME_TICKS = FRAME_TICKS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_tick,
  input  logic              punch_req,
  input  logic              facing_left,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        PosX,
  input  logic [9:0]        PosY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        index,
  output logic              pix_valid,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);

  logic [1:0] anim_frame;
  logic [1:0] frame_sel;

  ryu_punch_anim_fsm #(
    .FRAME_TICKS(FRAME_TICKS)
  ) u_anim (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .frame_tick(frame_tick),
    .punch_req (punch_req),
    .frame     (anim_frame),
    .busy      (busy),
    .done      (done)
  );

  // Stage 0: 11-bit compares so PosX+SPR_W past the screen edge never wraps
  logic [10:0]       dx, dy, px, py;
  logic              hit;
  logic [COL_W-1:0]  col, col_m;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;

  assign dx = {1'b0, DrawX};
  assign dy = {1'b0, DrawY};
  assign px = {1'b0, PosX};
  assign py = {1'b0, PosY};

  assign hit = (dx >= px) && (dx < px + 11'(SPR_W)) &&
               (dy >= py) && (dy < py + 11'(SPR_H));

  assign col   = COL_W'(dx - px);
  assign row   = ROW_W'(dy - py);
  assign col_m = facing_left ? (COL_W'(SPR_W - 1) - col) : col;

  // Frame numbers outside the ROM fall back to the idle frame
  assign frame_sel = (int'(anim_frame) < FRAMES) ? anim_frame : FRM_IDLE;

  assign addr = ADDR_W'(frame_sel) * ADDR_W'(SPR_W * SPR_H) +
                ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col_m);

  logic hit_d1, hit_d2;

  // Edge 1: register ROM address (held on miss) and the hit flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      hit_d1   <= 1'b0;
    end else begin
      if (hit) rom_addr <= addr;
      hit_d1 <= hit;
    end
  end

  // Edge 2: hit flag follows the ROM read latency
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) hit_d2 <= 1'b0;
    else          hit_d2 <= hit_d1;
  end

  // Edge 3: palette index; index 0 is transparent
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_valid <= 1'b0;
      index     <= 4'd0;
    end else begin
      pix_valid <= hit_d2 && (rom_q != 4'd0);
      index     <= (hit_d2 && (rom_q != 4'd0)) ? rom_q : 4'd0;
    end
  end

endmodule

// File: tb/tb_ryu_punch_sprite_fetch.sv
// Bench for ryu_punch_sprite_fetch: directed address table, hand-written
// animation/reset sequences, then random pixels against a reference model.
module tb_ryu_punch_sprite_fetch;

  localparam int SPR_W  = 64;
  localparam int SPR_H  = 96;
  localparam int FT     = 4;
  localparam int FRM_SZ = SPR_W * SPR_H;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  logic        frame_tick = 1'b0;
  logic        punch_req = 1'b0;
  logic        facing_left = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, PosX = '0, PosY = '0;
  logic [14:0] rom_addr;
  logic [3:0]  rom_q = '0;
  logic [3:0]  index;
  logic        pix_valid, busy, done;

  ryu_punch_sprite_fetch dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .punch_req  (punch_req),
    .facing_left(facing_left),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .PosX       (PosX),
    .PosY       (PosY),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .index      (index),
    .pix_valid  (pix_valid),
    .busy       (busy),
    .done       (done)
  );

  // Synchronous sprite ROM model with a few transparent entries
  function automatic logic [3:0] rom_fn(input int a);
    if (a % 17 == 0) return 4'd0;
    return 4'((a % 15) + 1);
  endfunction

  always @(posedge Clk) rom_q <= rom_fn(int'(rom_addr));

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_px(input int px, input int py, input int dx, input int dy, input bit fl);
    PosX = 10'(px); PosY = 10'(py); DrawX = 10'(dx); DrawY = 10'(dy); facing_left = fl;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int px, py, dx, dy;
    bit fl;
    int exp_addr;
    bit exp_hit;
  } vec_t;

  vec_t vecs[11];

  // ---------------- reference model state ----------------
  logic [4:0] exp_q[$];
  bit  m_active;
  int  m_ticks;
  int  m_exp_addr;
  bit  m_busy, m_done;

  function automatic int model_frame();
    if (!m_active)         return 0;
    if (m_ticks < FT)      return 1;
    if (m_ticks < 3 * FT)  return 2;
    return 1;
  endfunction

  initial begin
    logic [3:0] ev;
    logic [4:0] e;

    vecs[0]  = '{100, 50, 110, 60, 1'b0, 650, 1'b1};
    vecs[1]  = '{100, 50, 110, 60, 1'b1, 693, 1'b1};
    vecs[2]  = '{100, 50, 164, 60, 1'b0, 693, 1'b0};
    vecs[3]  = '{100, 50,  99, 60, 1'b0, 693, 1'b0};
    vecs[4]  = '{600,  0, 639,  0, 1'b0,  39, 1'b1};
    vecs[5]  = '{600,  0,   0,  0, 1'b0,  39, 1'b0};
    vecs[6]  = '{  0,  0,  63, 95, 1'b1, 6080, 1'b1};
    vecs[7]  = '{  0,  0,  64, 95, 1'b0, 6080, 1'b0};
    vecs[8]  = '{  0,  0,  63, 96, 1'b0, 6080, 1'b0};
    vecs[9]  = '{  0,  0,  17,  0, 1'b0,  17, 1'b1};
    vecs[10] = '{ 10, 20,  10, 20, 1'b1,  63, 1'b1};

    // 1. reset held with pixels that would otherwise hit
    for (int i = 0; i < 5; i++) begin
      drive_px(0, 0, $urandom_range(0, 63), $urandom_range(0, 95), 1'b0);
      step(1);
      chk("reset_outs", {rom_addr, index, pix_valid, busy, done}, 32'd0);
    end
    Reset_n = 1'b1;
    drive_px(0, 0, 5, 0, 1'b0);
    step(1);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_frame0", rom_addr, 5);

    // 2-4. address table, each vector held for the full 3-cycle latency
    for (int i = 0; i < 11; i++) begin
      drive_px(vecs[i].px, vecs[i].py, vecs[i].dx, vecs[i].dy, vecs[i].fl);
      step(1);
      chk($sformatf("vec%0d_addr", i), rom_addr, vecs[i].exp_addr);
      step(2);
      ev = (vecs[i].exp_hit && rom_fn(vecs[i].exp_addr) != 0) ? rom_fn(vecs[i].exp_addr) : 4'd0;
      chk($sformatf("vec%0d_index", i), index, ev);
      chk($sformatf("vec%0d_valid", i), pix_valid, ev != 0);
    end

    // 5. punch sequence; pixel at sprite origin so rom_addr = frame*FRM_SZ
    drive_px(0, 0, 0, 0, 1'b0);
    step(2);
    punch_req = 1'b1; step(1); punch_req = 1'b0;
    chk("punch_busy", busy, 1);
    step(1);
    chk("windup_frame", rom_addr, FRM_SZ);
    repeat (3) tick();
    step(1);
    chk("windup_hold", rom_addr, FRM_SZ);
    tick(); step(1);
    chk("extend_frame", rom_addr, 2 * FRM_SZ);
    punch_req = 1'b1; step(1); punch_req = 1'b0; step(1);
    chk("extend_ignore_punch", rom_addr, 2 * FRM_SZ);
    chk("extend_busy", busy, 1);
    repeat (7) tick();
    step(1);
    chk("extend_hold", rom_addr, 2 * FRM_SZ);
    tick(); step(1);
    chk("recover_frame", rom_addr, FRM_SZ);
    repeat (3) tick();
    chk("recover_no_done", done, 0);
    punch_req = 1'b1;
    tick();
    chk("done_pulse", done, 1);
    chk("done_not_busy", busy, 0);
    step(1);
    chk("done_one_cycle", done, 0);
    chk("held_restart", busy, 1);
    punch_req = 1'b0;
    repeat (4) tick();
    step(1);
    chk("extend_again", rom_addr, 2 * FRM_SZ);

    // 6. asynchronous reset mid-EXTEND
    tick(); tick();
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_outs", {rom_addr, index, pix_valid}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step(1);
    chk("rst_no_done", done, 0);
    punch_req = 1'b1; step(1); punch_req = 1'b0;
    step(1);
    chk("restart_windup", rom_addr, FRM_SZ);
    repeat (3) tick();
    step(1);
    chk("restart_cnt0", rom_addr, FRM_SZ);
    tick(); step(1);
    chk("restart_extend", rom_addr, 2 * FRM_SZ);

    // Random phase starts from a clean reset
    Reset_n = 1'b0;
    step(1);
    Reset_n = 1'b1;
    m_active = 0; m_ticks = 0; m_exp_addr = 0; m_busy = 0; m_done = 0;
    exp_q.delete();
    repeat (3) exp_q.push_back(5'd0);

    for (int n = 0; n < 800; n++) begin
      int px, py, dx, dy, addr, col, frm;
      bit fl, hit, pk, tk, v;
      logic [3:0] r;

      e = exp_q.pop_front();
      chk("rnd_addr", rom_addr, m_exp_addr);
      chk("rnd_pix", {pix_valid, index}, e);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_done", done, m_done);

      px = $urandom_range(0, 639);
      py = $urandom_range(0, 479);
      dx = px + $urandom_range(0, 79) - 8;
      dy = py + $urandom_range(0, 111) - 8;
      if (dx < 0) dx = 0;
      if (dx > 1023) dx = 1023;
      if (dy < 0) dy = 0;
      fl = 1'($urandom_range(0, 1));
      tk = ($urandom_range(0, 3) == 0);
      pk = ($urandom_range(0, 15) == 0);
      drive_px(px, py, dx, dy, fl);
      frame_tick = tk;
      punch_req = pk;

      frm = model_frame();
      hit = (dx >= px) && (dx < px + SPR_W) && (dy >= py) && (dy < py + SPR_H);
      addr = m_exp_addr;
      if (hit) begin
        col = dx - px;
        if (fl) col = SPR_W - 1 - col;
        addr = frm * FRM_SZ + (dy - py) * SPR_W + col;
      end
      r = rom_fn(addr);
      v = hit && (r != 0);
      exp_q.push_back({v, v ? r : 4'd0});
      m_exp_addr = addr;

      m_done = 0;
      if (!m_active) begin
        if (pk) begin m_active = 1; m_ticks = 0; end
      end else if (tk) begin
        m_ticks++;
        if (m_ticks == 4 * FT) begin m_active = 0; m_done = 1; end
      end
      m_busy = m_active;

      step(1);
    end
    frame_tick = 1'b0;
    punch_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
